// File: rtl/ubcsa_acc_stage_28_0.sv
// Two-stage operand/result wrapper around a 29-bit carry-select adder with a running accumulator.
// Optional build macro UBCSA_ACC_SAT_EN: saturate the accumulator on ACC carry-out instead of wrapping.

module UBCSe_28_0_28_0 (
  input  logic [28:0] a,
  input  logic [28:0] b,
  output logic [29:0] s
);
  localparam int BLK = 4;
  localparam int NB  = 8;

  logic [31:0] ap;
  logic [31:0] bp;
  logic [31:0] sp;
  logic        cy_out;
  logic        unused_bits;

  assign ap = {3'b000, a};
  assign bp = {3'b000, b};

  // Each block forms both carry-in hypotheses; the ripple only drives the selects.
  always_comb begin
    logic             cy;
    logic [BLK:0]     r0;
    logic [BLK:0]     r1;
    cy = 1'b0;
    sp = '0;
    r0 = '0;
    r1 = '0;
    for (int i = 0; i < NB; i++) begin
      r0 = {1'b0, ap[i*BLK +: BLK]} + {1'b0, bp[i*BLK +: BLK]};
      r1 = {1'b0, ap[i*BLK +: BLK]} + {1'b0, bp[i*BLK +: BLK]} + (BLK+1)'(1);
      sp[i*BLK +: BLK] = cy ? r1[BLK-1:0] : r0[BLK-1:0];
      cy = cy ? r1[BLK] : r0[BLK];
    end
    cy_out = cy;
  end

  assign s           = sp[29:0];
  assign unused_bits = ^{sp[31:30], cy_out};
endmodule

module ubcsa_acc_stage_28_0 (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [1:0]  IN_OP,
  input  logic [28:0] IN_X,
  input  logic [28:0] IN_Y,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [29:0] OUT_S,
  output logic        OUT_OVF,
  output logic [28:0] ACC_Q
);
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ACC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  logic        vld_p1;
  op_t         op_p1;
  logic [28:0] x_p1;
  logic [28:0] y_p1;
  logic [28:0] acc;
  logic        s1_adv;
  logic [28:0] b_p1;
  logic [29:0] sum_p1;
  logic [29:0] s_nxt;
  logic        ovf_nxt;
  logic [28:0] acc_nxt;

  function automatic logic [29:0] acc_result(input logic [29:0] sum);
`ifdef UBCSA_ACC_SAT_EN
    return sum[29] ? {1'b0, 29'h1FFF_FFFF} : sum;
`else
    return sum;
`endif
  endfunction

  assign s1_adv   = vld_p1 & (~OUT_VALID | OUT_READY);
  assign IN_READY = ~vld_p1 | s1_adv;
  assign ACC_Q    = acc;

  // Stage 1 -> stage 2: operand select, add, result shaping.
  assign b_p1 = (op_p1 == OP_ACC) ? acc : y_p1;

  UBCSe_28_0_28_0 u_add (
    .a (x_p1),
    .b (b_p1),
    .s (sum_p1)
  );

  always_comb begin
    s_nxt   = sum_p1;
    ovf_nxt = 1'b0;
    acc_nxt = acc;
    case (op_p1)
      OP_ADD: ;
      OP_ACC: begin
        s_nxt   = acc_result(sum_p1);
        ovf_nxt = sum_p1[29];
        acc_nxt = s_nxt[28:0];
      end
      OP_LOAD: begin
        s_nxt   = {1'b0, x_p1};
        acc_nxt = x_p1;
      end
      default: begin
        s_nxt   = '0;
        acc_nxt = '0;
      end
    endcase
  end

  // Accumulator moves with the op leaving stage 1, so a following ACC sees it next cycle.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      vld_p1    <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_S     <= '0;
      OUT_OVF   <= 1'b0;
      acc       <= '0;
    end else begin
      if (IN_READY) vld_p1 <= IN_VALID;
      if (s1_adv) begin
        OUT_VALID <= 1'b1;
        OUT_S     <= s_nxt;
        OUT_OVF   <= ovf_nxt;
        acc       <= acc_nxt;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

  // Input -> stage 1 operand capture.
  always_ff @(posedge CLK) begin
    if (IN_VALID && IN_READY) begin
      op_p1 <= op_t'(IN_OP);
      x_p1  <= IN_X;
      y_p1  <= IN_Y;
    end
  end
endmodule

// File: tb/tb_ubcsa_acc_stage_28_0.sv
// Directed and randomized bench for ubcsa_acc_stage_28_0 with a sequential reference model.
// Honors UBCSA_ACC_SAT_EN in the model when the design is built with it.

module tb_ubcsa_acc_stage_28_0;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [28:0] in_x;
  logic [28:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_s;
  logic        out_ovf;
  logic [28:0] acc_q;

  always #5 clk = ~clk;

  ubcsa_acc_stage_28_0 dut (
    .CLK       (clk),
    .RSTn      (rstn),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_OP     (in_op),
    .IN_X      (in_x),
    .IN_Y      (in_y),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_S     (out_s),
    .OUT_OVF   (out_ovf),
    .ACC_Q     (acc_q)
  );

  typedef struct packed {
    logic [29:0] s;
    logic        ovf;
    logic [28:0] acc;
  } exp_t;

  exp_t        sb[$];
  logic [29:0] obs_s[$];
  logic        obs_ovf[$];
  longint      macc;
  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  int          ncyc   = 0;
  logic        in_fire;
  logic        out_fire;
  logic        rdy_seen;
  logic [29:0] s_seen;

  localparam longint TWO29 = longint'(1) << 29;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ops take effect strictly in acceptance order.
  task automatic model_accept(input logic [1:0] op, input logic [28:0] x, input logic [28:0] y);
    exp_t   e;
    longint sum;
    e.ovf = 1'b0;
    case (op)
      2'd0: e.s = 30'(longint'(x) + longint'(y));
      2'd1: begin
        sum   = macc + longint'(x);
        e.ovf = (sum >= TWO29);
`ifdef UBCSA_ACC_SAT_EN
        if (sum >= TWO29) sum = TWO29 - 1;
        macc = sum;
`else
        macc = sum % TWO29;
`endif
        e.s = 30'(sum);
      end
      2'd2: begin
        macc = longint'(x);
        e.s  = 30'(x);
      end
      default: begin
        macc = 0;
        e.s  = '0;
      end
    endcase
    e.acc = 29'(macc);
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    rdy_seen = in_ready;
    s_seen   = out_s;
    if (rstn && out_fire) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_s", 64'(out_s), 64'(e.s));
        check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
        check("sb_acc", 64'(acc_q), 64'(e.acc));
      end
      obs_s.push_back(out_s);
      obs_ovf.push_back(out_ovf);
    end
    if (rstn && in_fire) model_accept(in_op, in_x, in_y);
    @(posedge clk);
    #1;
    ncyc++;
    if (!rstn) begin
      sb.delete();
      macc = 0;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [28:0] x, input logic [28:0] y);
    in_valid = 1'b1;
    in_op    = op;
    in_x     = x;
    in_y     = y;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (in_fire) break;
    end
    if (!in_fire) check("send_timeout", 64'(in_fire), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          base;
    int          k;
    logic [29:0] s_hold;
    logic [28:0] bx[4];
    logic [28:0] by[4];

    macc      = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) cyc();
    rstn = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_acc_q", 64'(acc_q), 64'd0);
    check("rst_out_s", 64'(out_s), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);

    // ADD with carry out, latency of one edge after acceptance.
    out_ready = 1'b1;
    send(2'd0, 29'h1FFF_FFFF, 29'd1);
    cyc();
    check("add_latency_valid", 64'(out_valid), 64'd1);
    check("add_s", 64'(out_s), 64'h2000_0000);
    check("add_ovf", 64'(out_ovf), 64'd0);
    drain(2);

    // Back-to-back accumulate chain.
    c0 = ncyc;
    send(2'd2, 29'd5, 29'd0);
    send(2'd1, 29'd7, 29'd0);
    send(2'd1, 29'd3, 29'd0);
    check("acc_no_bubble", 64'(ncyc - c0), 64'd3);
    drain(3);
    check("acc_chain_0", 64'(obs_s[obs_s.size()-3]), 64'd5);
    check("acc_chain_1", 64'(obs_s[obs_s.size()-2]), 64'd12);
    check("acc_chain_2", 64'(obs_s[obs_s.size()-1]), 64'd15);
    check("acc_chain_q", 64'(acc_q), 64'd15);

    // Accumulator overflow.
    send(2'd2, 29'h1FFF_FFF0, 29'd0);
    send(2'd1, 29'h20, 29'd0);
    drain(3);
`ifdef UBCSA_ACC_SAT_EN
    check("ovf_s", 64'(obs_s[obs_s.size()-1]), 64'h1FFF_FFFF);
    check("ovf_acc", 64'(acc_q), 64'h1FFF_FFFF);
`else
    check("ovf_s", 64'(obs_s[obs_s.size()-1]), 64'h2000_0010);
    check("ovf_acc", 64'(acc_q), 64'h10);
`endif
    check("ovf_flag", 64'(obs_ovf[obs_ovf.size()-1]), 64'd1);

    // Back-pressure: four ADDs, consumer stalled for three cycles.
    for (int i = 0; i < 4; i++) begin
      bx[i] = 29'(1000 + 17 * i);
      by[i] = 29'h1FFF_0000 + 29'(i);
    end
    base = obs_s.size();
    k = 0;
    s_hold = '0;
    for (int c = 0; c < 20 && obs_s.size() < base + 4; c++) begin
      out_ready = (c >= 3);
      if (k < 4) begin
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_x     = bx[k];
        in_y     = by[k];
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (in_fire) k++;
      if (c == 2) begin
        check("bp_ready_low", 64'(rdy_seen), 64'd0);
        check("bp_accepts", 64'(k), 64'd2);
        s_hold = s_seen;
      end
      if (c == 3) check("bp_hold", 64'(s_seen), 64'(s_hold));
    end
    in_valid = 1'b0;
    check("bp_count", 64'(obs_s.size() - base), 64'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < obs_s.size())
        check("bp_order", 64'(obs_s[base+i]), 64'(longint'(bx[i]) + longint'(by[i])));

    // Reset while both stages are full.
    out_ready = 1'b0;
    send(2'd2, 29'd9, 29'd0);
    send(2'd0, 29'd1, 29'd2);
    check("stall_acc_q", 64'(acc_q), 64'd9);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_acc", 64'(acc_q), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(2'd1, 29'd4, 29'd0);
    drain(2);
    check("post_rst_acc4", 64'(obs_s[obs_s.size()-1]), 64'd4);

    // Randomized traffic against the reference model.
    in_valid = 1'b0;
    in_fire  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || in_fire) begin
        in_valid = ($urandom_range(3) != 0);
        in_op    = 2'($urandom_range(3));
        in_x     = ($urandom_range(3) == 0) ? 29'h1FFF_FFFF - 29'($urandom_range(63)) : 29'($urandom);
        in_y     = 29'($urandom);
      end
      out_ready = ($urandom_range(2) != 0);
      cyc();
    end
    in_valid = 1'b0;
    drain(4);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
